// File: rtl/ahb_apb_pkg.sv
// rtl/ahb_apb_pkg.sv - shared state encodings, slave address map and select codes for the AHB-to-APB bridge
package ahb_apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WWAIT    = 3'd1,
    ST_READ     = 3'd2,
    ST_RENABLE  = 3'd3,
    ST_WRITE    = 3'd4,
    ST_WRITEP   = 3'd5,
    ST_WENABLE  = 3'd6,
    ST_WENABLEP = 3'd7
  } state_t;

  localparam logic [31:0] SLV0_BASE = 32'h8000_0000;
  localparam logic [31:0] SLV1_BASE = 32'h8400_0000;
  localparam logic [31:0] SLV2_BASE = 32'h8800_0000;
  localparam logic [31:0] SLV_LIMIT = 32'h8C00_0000;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_S0   = 3'b001;
  localparam logic [2:0] SEL_S1   = 3'b010;
  localparam logic [2:0] SEL_S2   = 3'b100;

endpackage

// File: rtl/apb_sel_decode.sv
// rtl/apb_sel_decode.sv - combinational address to one-hot APB slave select
module apb_sel_decode
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int NSLV   = 3
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [NSLV-1:0]   sel
);

  always_comb begin
    sel = NSLV'(SEL_NONE);
    if (addr >= ADDR_W'(SLV0_BASE) && addr < ADDR_W'(SLV1_BASE))
      sel = NSLV'(SEL_S0);
    else if (addr >= ADDR_W'(SLV1_BASE) && addr < ADDR_W'(SLV2_BASE))
      sel = NSLV'(SEL_S1);
    else if (addr >= ADDR_W'(SLV2_BASE) && addr < ADDR_W'(SLV_LIMIT))
      sel = NSLV'(SEL_S2);
  end

endmodule

// File: rtl/apb_fsm_controller.sv
// rtl/apb_fsm_controller.sv - APB-side SETUP/ACCESS sequencer of the AHB-to-APB bridge
// Optional APB_PREADY_EN adds a Pready input that can extend ACCESS phases.
module apb_fsm_controller
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSLV   = 3
) (
  input  logic              Hclk,
  input  logic              Hreset,
  input  logic              valid,
  input  logic              Hwrite,
  input  logic              Hwritereg,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [ADDR_W-1:0] Haddr1,
  input  logic [ADDR_W-1:0] Haddr2,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [DATA_W-1:0] Hwdata1,
`ifdef APB_PREADY_EN
  input  logic              Pready,
`endif
  output logic              Pwrite,
  output logic              Penable,
  output logic [NSLV-1:0]   Pselx,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Hreadyout
);

  state_t              r_state;
  state_t              w_state_nxt;
  state_t              w_idle_nxt;
  logic                w_stall;
  logic [ADDR_W-1:0]   w_paddr_nxt;
  logic [DATA_W-1:0]   w_pwdata_nxt;
  logic [NSLV-1:0]     w_sel_nxt;
  logic                r_pwrite;
  logic                r_penable;
  logic [NSLV-1:0]     r_pselx;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic                r_hreadyout;

  apb_sel_decode #(.ADDR_W(ADDR_W), .NSLV(NSLV)) u_sel_decode (
    .addr (w_paddr_nxt),
    .sel  (w_sel_nxt)
  );

  always_comb begin
    w_idle_nxt = ST_IDLE;
    if (valid)
      w_idle_nxt = Hwrite ? ST_WWAIT : ST_READ;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_stall      = 1'b0;
    w_paddr_nxt  = r_paddr;
    w_pwdata_nxt = r_pwdata;
    case (r_state)
      ST_IDLE, ST_RENABLE, ST_WENABLE: w_state_nxt = w_idle_nxt;
      ST_WWAIT:    w_state_nxt = valid ? ST_WRITEP : ST_WRITE;
      ST_READ:     w_state_nxt = ST_RENABLE;
      ST_WRITE:    w_state_nxt = valid ? ST_WENABLEP : ST_WENABLE;
      ST_WRITEP:   w_state_nxt = ST_WENABLEP;
      ST_WENABLEP: begin
        if (!Hwritereg)
          w_state_nxt = ST_READ;
        else
          w_state_nxt = valid ? ST_WRITEP : ST_WRITE;
      end
      default:     w_state_nxt = ST_IDLE;
    endcase
`ifdef APB_PREADY_EN
    if ((r_state == ST_RENABLE || r_state == ST_WENABLE || r_state == ST_WENABLEP) && !Pready) begin
      w_stall     = 1'b1;
      w_state_nxt = r_state;
    end
`endif
    // A write entering SETUP from WENABLEP is one pipeline stage deeper than one from WWAIT.
    case (w_state_nxt)
      ST_READ: if (!w_stall) w_paddr_nxt = Haddr;
      ST_WRITE, ST_WRITEP: begin
        if (r_state == ST_WENABLEP) begin
          w_paddr_nxt  = Haddr2;
          w_pwdata_nxt = Hwdata1;
        end else begin
          w_paddr_nxt  = Haddr1;
          w_pwdata_nxt = Hwdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      r_state     <= ST_IDLE;
      r_pwrite    <= 1'b0;
      r_penable   <= 1'b0;
      r_pselx     <= '0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_hreadyout <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_stall) begin
        r_hreadyout <= 1'b0;
      end else begin
        case (w_state_nxt)
          ST_IDLE, ST_WWAIT: begin
            r_pselx     <= '0;
            r_penable   <= 1'b0;
            r_hreadyout <= 1'b1;
          end
          ST_READ: begin
            r_paddr     <= w_paddr_nxt;
            r_pselx     <= w_sel_nxt;
            r_pwrite    <= 1'b0;
            r_penable   <= 1'b0;
            r_hreadyout <= 1'b0;
          end
          ST_WRITE, ST_WRITEP: begin
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_pselx     <= w_sel_nxt;
            r_pwrite    <= 1'b1;
            r_penable   <= 1'b0;
            r_hreadyout <= (w_state_nxt == ST_WRITE);
          end
          ST_RENABLE, ST_WENABLE: begin
            r_penable   <= 1'b1;
            r_hreadyout <= 1'b1;
          end
          ST_WENABLEP: begin
            r_penable   <= 1'b1;
            r_hreadyout <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign Pwrite    = r_pwrite;
  assign Penable   = r_penable;
  assign Pselx     = r_pselx;
  assign Paddr     = r_paddr;
  assign Pwdata    = r_pwdata;
  assign Hreadyout = r_hreadyout;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// tb/tb_apb_fsm_controller.sv - directed self-checking bench for apb_fsm_controller
module tb_apb_fsm_controller;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic        valid, Hwrite, Hwritereg;
  logic [31:0] Haddr, Haddr1, Haddr2, Hwdata, Hwdata1;
`ifdef APB_PREADY_EN
  logic        Pready;
`endif
  logic        Pwrite, Penable, Hreadyout;
  logic [2:0]  Pselx;
  logic [31:0] Paddr, Pwdata;

  int total = 0;
  int bad   = 0;

  always #5 Hclk = ~Hclk;

  apb_fsm_controller #(.ADDR_W(32), .DATA_W(32), .NSLV(3)) dut (
    .Hclk      (Hclk),
    .Hreset    (Hreset),
    .valid     (valid),
    .Hwrite    (Hwrite),
    .Hwritereg (Hwritereg),
    .Haddr     (Haddr),
    .Haddr1    (Haddr1),
    .Haddr2    (Haddr2),
    .Hwdata    (Hwdata),
    .Hwdata1   (Hwdata1),
`ifdef APB_PREADY_EN
    .Pready    (Pready),
`endif
    .Pwrite    (Pwrite),
    .Penable   (Penable),
    .Pselx     (Pselx),
    .Paddr     (Paddr),
    .Pwdata    (Pwdata),
    .Hreadyout (Hreadyout)
  );

  task automatic step();
    @(posedge Hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [2:0] sel, input logic en,
                         input logic wr, input logic rdy);
    chk({tag, "_sel"}, {29'd0, Pselx}, {29'd0, sel});
    chk({tag, "_en"},  {31'd0, Penable}, {31'd0, en});
    chk({tag, "_wr"},  {31'd0, Pwrite}, {31'd0, wr});
    chk({tag, "_rdy"}, {31'd0, Hreadyout}, {31'd0, rdy});
  endtask

  initial begin
    Hreset = 1'b1; valid = 1'b0; Hwrite = 1'b0; Hwritereg = 1'b0;
    Haddr = '0; Haddr1 = '0; Haddr2 = '0; Hwdata = '0; Hwdata1 = '0;
`ifdef APB_PREADY_EN
    Pready = 1'b1;
`endif
    #2;
    step(); step();
    chk_ctl("rst", 3'b000, 1'b0, 1'b0, 1'b1);
    chk("rst_paddr", Paddr, 32'h0);
    chk("rst_pwdata", Pwdata, 32'h0);
    Hreset = 1'b0;

    // single read
    valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h8000_0010;
    step();
    chk_ctl("rd_setup", 3'b001, 1'b0, 1'b0, 1'b0);
    chk("rd_setup_paddr", Paddr, 32'h8000_0010);
    valid = 1'b0;
    step();
    chk_ctl("rd_access", 3'b001, 1'b1, 1'b0, 1'b1);
    chk("rd_access_paddr", Paddr, 32'h8000_0010);
    step();
    chk_ctl("rd_idle", 3'b000, 1'b0, 1'b0, 1'b1);

    // single write
    valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8400_0004;
    step();
    chk_ctl("wr_wwait", 3'b000, 1'b0, 1'b0, 1'b1);
    valid = 1'b0; Hwrite = 1'b0; Hwritereg = 1'b1;
    Haddr1 = 32'h8400_0004; Hwdata = 32'hA5A5_A5A5;
    step();
    chk_ctl("wr_setup", 3'b010, 1'b0, 1'b1, 1'b1);
    chk("wr_setup_paddr", Paddr, 32'h8400_0004);
    chk("wr_setup_pwdata", Pwdata, 32'hA5A5_A5A5);
    Hwritereg = 1'b0;
    step();
    chk_ctl("wr_access", 3'b010, 1'b1, 1'b1, 1'b1);
    step();
    chk_ctl("wr_idle", 3'b000, 1'b0, 1'b1, 1'b1);

    // back-to-back writes
    valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8800_0000;
    step();
    Hwritereg = 1'b1; Haddr = 32'h8800_0004; Haddr1 = 32'h8800_0000; Hwdata = 32'h1;
    step();
    chk_ctl("b2b_writep", 3'b100, 1'b0, 1'b1, 1'b0);
    chk("b2b_writep_paddr", Paddr, 32'h8800_0000);
    chk("b2b_writep_pwdata", Pwdata, 32'h1);
    valid = 1'b0; Hwrite = 1'b0;
    step();
    chk_ctl("b2b_wenablep", 3'b100, 1'b1, 1'b1, 1'b0);
    chk("b2b_wenablep_paddr", Paddr, 32'h8800_0000);
    Haddr2 = 32'h8800_0004; Hwdata1 = 32'h2;
    step();
    chk_ctl("b2b_write", 3'b100, 1'b0, 1'b1, 1'b1);
    chk("b2b_write_paddr", Paddr, 32'h8800_0004);
    chk("b2b_write_pwdata", Pwdata, 32'h2);
    Hwritereg = 1'b0;
    step();
    chk_ctl("b2b_wenable", 3'b100, 1'b1, 1'b1, 1'b1);
    step();
    chk_ctl("b2b_idle", 3'b000, 1'b0, 1'b1, 1'b1);

    // pipelined write then read
    valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8000_0000;
    step();
    Hwrite = 1'b0; Hwritereg = 1'b1; Haddr = 32'h8400_0000;
    Haddr1 = 32'h8000_0000; Hwdata = 32'h1234_5678;
    step();
    chk_ctl("wr_rd_writep", 3'b001, 1'b0, 1'b1, 1'b0);
    chk("wr_rd_writep_pwdata", Pwdata, 32'h1234_5678);
    Hwritereg = 1'b0;
    step();
    chk_ctl("wr_rd_wenablep", 3'b001, 1'b1, 1'b1, 1'b0);
    valid = 1'b0;
    step();
    chk_ctl("wr_rd_read", 3'b010, 1'b0, 1'b0, 1'b0);
    chk("wr_rd_read_paddr", Paddr, 32'h8400_0000);
    step();
    chk_ctl("wr_rd_renable", 3'b010, 1'b1, 1'b0, 1'b1);
    step();
    chk_ctl("wr_rd_idle", 3'b000, 1'b0, 1'b0, 1'b1);

    // address map boundaries
    valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h83FF_FFFF;
    step();
    chk_ctl("bnd_s0_top", 3'b001, 1'b0, 1'b0, 1'b0);
    valid = 1'b0;
    step(); step();
    valid = 1'b1; Haddr = 32'h8BFF_FFFC;
    step();
    chk_ctl("bnd_s2_top", 3'b100, 1'b0, 1'b0, 1'b0);
    valid = 1'b0;
    step(); step();
    valid = 1'b1; Haddr = 32'h8C00_0000;
    step();
    chk_ctl("bnd_limit", 3'b000, 1'b0, 1'b0, 1'b0);
    chk("bnd_limit_paddr", Paddr, 32'h8C00_0000);
    valid = 1'b0;
    step(); step();
    valid = 1'b1; Haddr = 32'h7FFF_FFFC;
    step();
    chk_ctl("bnd_below", 3'b000, 1'b0, 1'b0, 1'b0);
    valid = 1'b0;
    step(); step();

    // reset in the middle of a write access
    valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8000_0008;
    step();
    valid = 1'b0; Hwrite = 1'b0; Haddr1 = 32'h8000_0008; Hwdata = 32'hCAFE_F00D;
    step();
    step();
    chk_ctl("mid_wenable", 3'b001, 1'b1, 1'b1, 1'b1);
    Hreset = 1'b1;
    step();
    chk_ctl("mid_rst", 3'b000, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_paddr", Paddr, 32'h0);
    step();
    Hreset = 1'b0;
    step();
    chk_ctl("post_rst_idle", 3'b000, 1'b0, 1'b0, 1'b1);
    valid = 1'b1; Haddr = 32'h8400_0020;
    step();
    chk_ctl("post_rst_read", 3'b010, 1'b0, 1'b0, 1'b0);
    valid = 1'b0;
    step(); step();

`ifdef APB_PREADY_EN
    // ACCESS extended by Pready low for two cycles
    valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h8000_0040;
    step();
    valid = 1'b0; Pready = 1'b0;
    step();
    chk_ctl("rdy_acc1", 3'b001, 1'b1, 1'b0, 1'b1);
    step();
    chk_ctl("rdy_acc2", 3'b001, 1'b1, 1'b0, 1'b0);
    chk("rdy_acc2_paddr", Paddr, 32'h8000_0040);
    Pready = 1'b0;
    step();
    chk_ctl("rdy_acc3", 3'b001, 1'b1, 1'b0, 1'b0);
    chk("rdy_acc3_paddr", Paddr, 32'h8000_0040);
    Pready = 1'b1;
    step();
    chk_ctl("rdy_idle", 3'b000, 1'b0, 1'b0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
